// File: rtl/census_wta_if.sv
// Custom-instruction bus for census_wta: clock enable, start/op request, operands, and the result/done return.
interface census_wta_if;
  logic        clk_en;
  logic        start;
  logic [3:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, start, n, dataa, datab, input result, done);
  modport slave  (input clk_en, start, n, dataa, datab, output result, done);
endinterface

// File: rtl/census_wta.sv
// Hamming-cost winner-takes-all tracker for census signature pairs, one pair per disparity candidate.
// CENSUS_WTA_UNIQ_EN adds a second-best register and the uniqueness flag (result bit 30).
module census_wta #(
  parameter int W           = 32,
  parameter int DISP_BITS   = 6,
  parameter int UNIQ_MARGIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  census_wta_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [31:0]          MASK     = 32'hFFFF_FFFF >> (32 - W);
  localparam logic [DISP_BITS-1:0] DISP_MAX = '1;
  localparam logic [DISP_BITS-1:0] DISP_ONE = 1;

  // state    | meaning
  // ST_IDLE  | waiting for start
  // ST_P1    | per-byte popcounts of the latched XOR
  // ST_P2    | cost sum, WTA update, done
  // ST_RD    | CLEAR / READ_* completion, done
  typedef enum logic [1:0] {ST_IDLE, ST_P1, ST_P2, ST_RD} state_t;

  state_t               state_q;
  logic [3:0]           op_q;
  logic [31:0]          x_q;
  logic [3:0][3:0]      pc_q, pc_d;
  logic [5:0]           sum_w;
  logic [CW-1:0]        cost_d;
  logic [CW-1:0]        best_cost_q, best_cost_d;
  logic [DISP_BITS-1:0] best_disp_q, best_disp_d;
  logic [DISP_BITS-1:0] disp_cnt_q, disp_cnt_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        last_cost_q;
  logic                 uniq_now, uniq_push;
  logic [31:0]          result_q;
  logic                 done_q;
`ifdef CENSUS_WTA_UNIQ_EN
  logic [CW-1:0]        second_q, second_d;
`endif

  function automatic logic uniq_of(input logic [CW-1:0] sec, input logic [CW-1:0] best);
    return int'(sec - best) >= UNIQ_MARGIN;
  endfunction

  function automatic logic [31:0] pack(input logic o, input logic u,
                                       input logic [DISP_BITS-1:0] d, input logic [CW-1:0] c);
    logic [7:0] d8;
    logic [7:0] c8;
    d8 = 8'(d);
    c8 = 8'(c);
    return {o, u, 6'b0, d8, 8'b0, c8};
  endfunction

  always_comb begin
    pc_d = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) pc_d[b] = pc_d[b] + {3'b000, x_q[8*b+k]};
    end
    sum_w  = {2'b00, pc_q[0]} + {2'b00, pc_q[1]} + {2'b00, pc_q[2]} + {2'b00, pc_q[3]};
    cost_d = sum_w[CW-1:0];
  end

  // Once the last candidate index has been consumed, further pushes only flag overflow.
  always_comb begin
    best_cost_d = best_cost_q;
    best_disp_d = best_disp_q;
    disp_cnt_d  = disp_cnt_q;
    sat_d       = sat_q;
    ovf_d       = ovf_q;
`ifdef CENSUS_WTA_UNIQ_EN
    second_d    = second_q;
`endif
    if (sat_q) begin
      ovf_d = 1'b1;
    end else begin
      if (cost_d < best_cost_q) begin
        best_cost_d = cost_d;
        best_disp_d = disp_cnt_q;
`ifdef CENSUS_WTA_UNIQ_EN
        second_d    = best_cost_q;
      end else if (cost_d < second_q) begin
        second_d    = cost_d;
`endif
      end
      if (disp_cnt_q == DISP_MAX) sat_d = 1'b1;
      else                        disp_cnt_d = disp_cnt_q + DISP_ONE;
    end
`ifdef CENSUS_WTA_UNIQ_EN
    uniq_now  = uniq_of(second_q, best_cost_q);
    uniq_push = uniq_of(second_d, best_cost_d);
`else
    uniq_now  = 1'b0;
    uniq_push = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      x_q         <= '0;
      pc_q        <= '0;
      best_cost_q <= '1;
      best_disp_q <= '0;
      disp_cnt_q  <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      last_cost_q <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
`ifdef CENSUS_WTA_UNIQ_EN
      second_q    <= '1;
`endif
    end else if (bus.clk_en) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q <= bus.n;
            if (bus.n == 4'd1) begin
              x_q     <= (bus.dataa ^ bus.datab) & MASK;
              state_q <= ST_P1;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_P1: begin
          pc_q    <= pc_d;
          state_q <= ST_P2;
        end
        ST_P2: begin
          last_cost_q <= cost_d;
          best_cost_q <= best_cost_d;
          best_disp_q <= best_disp_d;
          disp_cnt_q  <= disp_cnt_d;
          sat_q       <= sat_d;
          ovf_q       <= ovf_d;
`ifdef CENSUS_WTA_UNIQ_EN
          second_q    <= second_d;
`endif
          result_q    <= pack(ovf_d, uniq_push, best_disp_d, cost_d);
          done_q      <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_RD: begin
          case (op_q)
            4'd0: begin
              best_cost_q <= '1;
              best_disp_q <= '0;
              disp_cnt_q  <= '0;
              sat_q       <= 1'b0;
              ovf_q       <= 1'b0;
              last_cost_q <= '0;
`ifdef CENSUS_WTA_UNIQ_EN
              second_q    <= '1;
`endif
              result_q    <= '0;
            end
            4'd3: result_q <= {24'b0, 8'(last_cost_q)};
            4'd4: result_q <= {24'b0, 8'(disp_cnt_q)};
`ifdef CENSUS_WTA_UNIQ_EN
            4'd5: result_q <= {24'b0, 8'(second_q)};
`else
            4'd5: result_q <= '0;
`endif
            default: result_q <= pack(ovf_q, uniq_now, best_disp_q, best_cost_q);
          endcase
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule
